approx_adder_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively exercises one combinational approximate adder instance (two OP_W-bit operands, OP_W+1-bit sum) and grades it against the exact sum.
- Drives every operand pair once and samples the approximate result.
- Reports max absolute error, error count, first violating vector, and pass/fail against a runtime error threshold.
- Sits beside an approximate-adder netlist in the silicon/FPGA characterisation harness.

---
 rtl/approx_adder_sweep_ctrl_pkg.sv | 25 ++
 rtl/approx_adder_sweep_ctrl_if.sv | 45 ++++
 rtl/approx_adder_sweep_ctrl_err_stage.sv | 107 ++++++++++
 rtl/approx_adder_sweep_ctrl.sv | 116 +++++++++++
 tb/tb_approx_adder_sweep_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/approx_adder_sweep_ctrl_pkg.sv
// Shared types and helpers for the approximate-adder sweep controller.
package approx_sweep_pkg;

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

   function automatic int n_vec(input int op_w);
      return 1 << (2 * op_w);
   endfunction

   // err_count must hold N itself, hence one bit more than the vector index.
   function automatic int cnt_w(input int op_w);
      return 2 * op_w + 1;
   endfunction

   function automatic logic [31:0] abs_diff(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          err_w);
      logic [31:0] d;
      logic [31:0] lim;
      d   = (a >= b) ? (a - b) : (b - a);
      lim = (32'd1 << err_w) - 32'd1;
      return (d > lim) ? lim : d;
   endfunction

endpackage

// File: rtl/approx_adder_sweep_ctrl_if.sv
// Harness-facing bundle: control/threshold in, adder operands out, grades out.
// APPROX_SWEEP_ERR_SUM_EN adds the err_sum accumulator output.
interface approx_adder_sweep_ctrl_if #(
   parameter int OP_W  = 2,
   parameter int ERR_W = OP_W + 1
);
   localparam int CNT_W = 2 * OP_W + 1;

   logic                   start;
   logic                   abort;
   logic [ERR_W-1:0]       et;
   logic [OP_W-1:0]        op_a;
   logic [OP_W-1:0]        op_b;
   logic [ERR_W-1:0]       approx_sum;
   logic                   busy;
   logic                   done;
   logic                   valid;
   logic [ERR_W-1:0]       max_err;
   logic [CNT_W-1:0]       err_count;
   logic                   pass;
   logic [2*OP_W-1:0]      fail_vec;
   logic                   fail_seen;
`ifdef APPROX_SWEEP_ERR_SUM_EN
   logic [2*OP_W+ERR_W-1:0] err_sum;
`endif

   modport master (
      output start, abort, et, approx_sum,
      input  op_a, op_b, busy, done, valid, max_err, err_count, pass,
             fail_vec, fail_seen
`ifdef APPROX_SWEEP_ERR_SUM_EN
      , err_sum
`endif
   );

   modport slave (
      input  start, abort, et, approx_sum,
      output op_a, op_b, busy, done, valid, max_err, err_count, pass,
             fail_vec, fail_seen
`ifdef APPROX_SWEEP_ERR_SUM_EN
      , err_sum
`endif
   );

endinterface

// File: rtl/approx_adder_sweep_ctrl_err_stage.sv
// Sample register (stage 1) and error statistics update (stage 2).
// APPROX_SWEEP_ERR_SUM_EN adds the running error sum.
module approx_err_stage
   import approx_sweep_pkg::*;
#(
   parameter int OP_W  = 2,
   parameter int ERR_W = OP_W + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  flush_i,
   input  logic                  smp_i,
   input  logic [ERR_W-1:0]      approx_i,
   input  logic [ERR_W-1:0]      exact_i,
   input  logic [2*OP_W-1:0]     vec_i,
   input  logic [ERR_W-1:0]      et_i,
   output logic [ERR_W-1:0]      max_err_o,
   output logic [2*OP_W:0]       err_count_o,
   output logic [2*OP_W-1:0]     fail_vec_o,
   output logic                  fail_seen_o
`ifdef APPROX_SWEEP_ERR_SUM_EN
   ,
   output logic [2*OP_W+ERR_W-1:0] err_sum_o
`endif
);
   localparam int CNT_W = cnt_w(OP_W);
   localparam int VEC_W = 2 * OP_W;

   logic                s1_vld_q;
   logic [ERR_W-1:0]    s1_approx_q;
   logic [ERR_W-1:0]    s1_exact_q;
   logic [VEC_W-1:0]    s1_vec_q;

   logic [ERR_W-1:0]    err;
   logic [ERR_W-1:0]    max_err_q, max_err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [VEC_W-1:0]    fvec_q, fvec_d;
   logic                fseen_q, fseen_d;
`ifdef APPROX_SWEEP_ERR_SUM_EN
   localparam int SUM_W = 2 * OP_W + ERR_W;
   logic [SUM_W-1:0]    sum_q, sum_d;
`endif

   assign err = ERR_W'(abs_diff(32'(s1_approx_q), 32'(s1_exact_q), ERR_W));

   always_comb begin
      max_err_d = max_err_q;
      cnt_d     = cnt_q;
      fvec_d    = fvec_q;
      fseen_d   = fseen_q;
`ifdef APPROX_SWEEP_ERR_SUM_EN
      sum_d     = sum_q;
`endif
      if (s1_vld_q) begin
         if (err > max_err_q) max_err_d = err;
         cnt_d = cnt_q + CNT_W'(err != '0);
         // Only the first offending vector is kept.
         if ((err > et_i) && !fseen_q) begin
            fvec_d  = s1_vec_q;
            fseen_d = 1'b1;
         end
`ifdef APPROX_SWEEP_ERR_SUM_EN
         sum_d = sum_q + SUM_W'(err);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         s1_vld_q    <= 1'b0;
         s1_approx_q <= '0;
         s1_exact_q  <= '0;
         s1_vec_q    <= '0;
         max_err_q   <= '0;
         cnt_q       <= '0;
         fvec_q      <= '0;
         fseen_q     <= 1'b0;
`ifdef APPROX_SWEEP_ERR_SUM_EN
         sum_q       <= '0;
`endif
      end else begin
         s1_vld_q <= smp_i && !flush_i;
         if (smp_i) begin
            s1_approx_q <= approx_i;
            s1_exact_q  <= exact_i;
            s1_vec_q    <= vec_i;
         end
         max_err_q <= max_err_d;
         cnt_q     <= cnt_d;
         fvec_q    <= fvec_d;
         fseen_q   <= fseen_d;
`ifdef APPROX_SWEEP_ERR_SUM_EN
         sum_q     <= sum_d;
`endif
      end
   end

   assign max_err_o   = max_err_q;
   assign err_count_o = cnt_q;
   assign fail_vec_o  = fvec_q;
   assign fail_seen_o = fseen_q;
`ifdef APPROX_SWEEP_ERR_SUM_EN
   assign err_sum_o   = sum_q;
`endif

endmodule

// File: rtl/approx_adder_sweep_ctrl.sv
// Exhaustive sweep sequencer grading one combinational approximate adder.
// APPROX_SWEEP_ERR_SUM_EN enables the err_sum output.
module approx_adder_sweep_ctrl
   import approx_sweep_pkg::*;
#(
   parameter int OP_W  = 2,
   parameter int ERR_W = OP_W + 1
) (
   input logic                      clk,
   input logic                      rst,
   approx_adder_sweep_ctrl_if.slave bus
);
   localparam int N     = n_vec(OP_W);
   localparam int VEC_W = 2 * OP_W;

   state_e             state_q;
   logic [VEC_W-1:0]   vec_q;
   logic [ERR_W-1:0]   et_q;
   logic               busy_q;
   logic               done_q;
   logic               valid_q;

   logic               start_acc;
   logic               abort_acc;
   logic [ERR_W-1:0]   exact;
   logic [ERR_W-1:0]   max_err;

   assign start_acc = (state_q == IDLE) && bus.start;
   assign abort_acc = ((state_q == SWEEP) || (state_q == DRAIN)) && bus.abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         et_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q <= SWEEP;
                  vec_q   <= '0;
                  et_q    <= bus.et;
                  busy_q  <= 1'b1;
                  valid_q <= 1'b0;
               end
            end
            SWEEP: begin
               if (bus.abort) begin
                  state_q <= IDLE;
                  vec_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (vec_q == VEC_W'(N - 1)) begin
                  state_q <= DRAIN;
                  vec_q   <= '0;
               end else begin
                  vec_q   <= vec_q + 1'b1;
               end
            end
            DRAIN: begin
               busy_q <= 1'b0;
               if (bus.abort) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  valid_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The counter doubles as the operand register, so op_a/op_b go to 0 whenever vec_q is idle.
   assign bus.op_a = vec_q[OP_W-1:0];
   assign bus.op_b = vec_q[VEC_W-1:OP_W];
   assign exact    = ERR_W'(vec_q[OP_W-1:0]) + ERR_W'(vec_q[VEC_W-1:OP_W]);

   approx_err_stage #(
      .OP_W  (OP_W),
      .ERR_W (ERR_W)
   ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (start_acc),
      .flush_i     (abort_acc),
      .smp_i       (state_q == SWEEP),
      .approx_i    (bus.approx_sum),
      .exact_i     (exact),
      .vec_i       (vec_q),
      .et_i        (et_q),
      .max_err_o   (max_err),
      .err_count_o (bus.err_count),
      .fail_vec_o  (bus.fail_vec),
      .fail_seen_o (bus.fail_seen)
`ifdef APPROX_SWEEP_ERR_SUM_EN
      ,
      .err_sum_o   (bus.err_sum)
`endif
   );

   assign bus.max_err = max_err;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.valid   = valid_q;
   // Gated by valid so the idle/reset value reads 0 instead of a stale compare.
   assign bus.pass    = valid_q && (max_err <= et_q);

endmodule

// File: tb/tb_approx_adder_sweep_ctrl.sv
// Scoreboard bench for approx_adder_sweep_ctrl with a behavioural adder model.
module tb_approx_adder_sweep_ctrl;
   localparam int OP_W = 2;
   localparam int N    = 1 << (2 * OP_W);

   logic clk = 1'b0;
   logic rst;
   int   mode;
   int   n_chk = 0;
   int   n_err = 0;

   typedef struct {
      int max_err;
      int cnt;
      int pass;
      int fseen;
      int fvec;
      int sum;
   } exp_t;

   exp_t sb[$];

   approx_adder_sweep_ctrl_if #(.OP_W(OP_W)) bus ();

   approx_adder_sweep_ctrl #(.OP_W(OP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // 0: exact adder, 1: constant 3, 2: constant 7
   always_comb begin
      case (mode)
         1:       bus.approx_sum = 3'd3;
         2:       bus.approx_sum = 3'd7;
         default: bus.approx_sum = {1'b0, bus.op_a} + {1'b0, bus.op_b};
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input int md, input int thr);
      exp_t m;
      int a, b, ex, ap, e;
      m = '{default: 0};
      for (int v = 0; v < N; v++) begin
         a  = v % 4;
         b  = v / 4;
         ex = a + b;
         ap = (md == 1) ? 3 : (md == 2) ? 7 : ex;
         e  = (ap > ex) ? ap - ex : ex - ap;
         if (e > m.max_err) m.max_err = e;
         if (e != 0) m.cnt++;
         m.sum += e;
         if (e > thr && m.fseen == 0) begin
            m.fseen = 1;
            m.fvec  = v;
         end
      end
      m.pass = (m.max_err <= thr) ? 1 : 0;
      return m;
   endfunction

   task automatic check_zero(input string p);
      chk({p, "_op_a"}, bus.op_a, 0);
      chk({p, "_op_b"}, bus.op_b, 0);
      chk({p, "_busy"}, bus.busy, 0);
      chk({p, "_done"}, bus.done, 0);
      chk({p, "_valid"}, bus.valid, 0);
      chk({p, "_max_err"}, bus.max_err, 0);
      chk({p, "_err_count"}, bus.err_count, 0);
      chk({p, "_pass"}, bus.pass, 0);
      chk({p, "_fail_vec"}, bus.fail_vec, 0);
      chk({p, "_fail_seen"}, bus.fail_seen, 0);
`ifdef APPROX_SWEEP_ERR_SUM_EN
      chk({p, "_err_sum"}, bus.err_sum, 0);
`endif
   endtask

   // repulse: SWEEP cycle at which start is re-asserted (0 = never)
   task automatic run_sweep(input string p, input int md, input int thr,
                            input int repulse, input bit with_abort);
      int   cyc;
      int   bz;
      exp_t e;
      mode      = md;
      bus.et    = 3'(thr);
      bus.start = 1'b1;
      bus.abort = with_abort;
      sb.push_back(model(md, thr));
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      cyc = 1;
      bz  = 0;
      while (bus.done !== 1'b1 && cyc < 100) begin
         if (bus.busy) bz++;
         if (cyc == repulse) begin
            bus.start = 1'b1;
            bus.et    = 3'd0;
         end
         tick();
         bus.start = 1'b0;
         cyc++;
      end
      chk({p, "_done_lat"}, cyc, N + 2);
      chk({p, "_busy_cyc"}, bz, N + 1);
      chk({p, "_valid"}, bus.valid, 1);
      if (sb.size() == 0) begin
         chk({p, "_sb_nonempty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         chk({p, "_max_err"}, bus.max_err, e.max_err);
         chk({p, "_err_count"}, bus.err_count, e.cnt);
         chk({p, "_pass"}, bus.pass, e.pass);
         chk({p, "_fail_seen"}, bus.fail_seen, e.fseen);
         if (e.fseen != 0) chk({p, "_fail_vec"}, bus.fail_vec, e.fvec);
`ifdef APPROX_SWEEP_ERR_SUM_EN
         chk({p, "_err_sum"}, bus.err_sum, e.sum);
`endif
      end
      tick();
      chk({p, "_done_pulse"}, bus.done, 0);
      chk({p, "_valid_hold"}, bus.valid, 1);
   endtask

   initial begin
      int pulses;
      rst       = 1'b1;
      mode      = 0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.et    = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_zero("reset");

      run_sweep("c3_et3", 1, 3, 0, 1'b0);
      run_sweep("c3_et2", 1, 2, 0, 1'b0);
      run_sweep("exact_et0", 0, 0, 0, 1'b0);

      // abort at SWEEP cycle 7
      mode      = 1;
      bus.et    = 3'd3;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 7; c++) tick();
      chk("abort_op_a_mid", bus.op_a, 2);
      chk("abort_op_b_mid", bus.op_b, 1);
      chk("abort_busy_mid", bus.busy, 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_op_a", bus.op_a, 0);
      chk("abort_op_b", bus.op_b, 0);
      chk("abort_valid", bus.valid, 0);
      chk("abort_pass", bus.pass, 0);
      pulses = 0;
      for (int c = 0; c < 25; c++) begin
         if (bus.done) pulses++;
         tick();
      end
      chk("abort_no_done", pulses, 0);
      chk("abort_valid_late", bus.valid, 0);

      run_sweep("repulse", 1, 3, 5, 1'b0);

      // reset during SWEEP cycle 5
      mode      = 1;
      bus.et    = 3'd3;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("midrst");
      run_sweep("post_rst", 1, 3, 0, 1'b0);

      run_sweep("c7_et7_startabort", 2, 7, 0, 1'b1);

      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
